// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds a single uart_tx. Holds the winning byte until the
// transmitter reports completion or a watchdog gives up on it.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         last_q, last_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  win_found;
  logic [GW-1:0]         win_idx;

  // Rotating search starting one past the previous winner.
  always_comb begin
    int            idx;
    logic [GW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = GW'(idx);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    req_ready   = '0;
    tx_start    = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          data_d  = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
          grant_d = win_idx;
          last_d  = win_idx;
          state_d = START;
        end
      end
      START: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          cnt_d    = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // Completion wins over an expiry in the same cycle.
        if (tx_done) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= GW'(NUM_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx_data  = data_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

endmodule
